// File: rtl/ni_packetizer.sv
// ni_packetizer: injection-side packetizer of the network interface.
// Takes a message descriptor (dest, len) and a payload word stream from the frontend and
// emits head/body/tail flits toward the local router port. Injection is paced by
// credit-based flow control against the router input buffer.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   msg_valid/ready         descriptor handshake; msg_dest, msg_len sampled on accept
//   pld_valid/ready         payload word handshake; pld_data
//   flit_valid, flit_data   registered flit push {type[1:0], DATA_W bits}
//                           type: 01 head, 00 body, 10 tail, 11 head+tail
//   credit_in               one-cycle pulse, router freed one buffer slot
//   credit_cnt              current credit count (resets to CREDITS)
//   credit_err              sticky overflow flag: credit returned while already full
//   busy                    FSM not idle
module ni_packetizer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEST_W  = 4,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CREDITS = 4,
  localparam int unsigned CNT_W  = $clog2(CREDITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              msg_valid,
  output logic              msg_ready,
  input  logic [DEST_W-1:0] msg_dest,
  input  logic [LEN_W-1:0]  msg_len,
  input  logic              pld_valid,
  output logic              pld_ready,
  input  logic [DATA_W-1:0] pld_data,
  output logic              flit_valid,
  output logic [DATA_W+1:0] flit_data,
  input  logic              credit_in,
  output logic [CNT_W-1:0]  credit_cnt,
  output logic              credit_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CreditsMax = CNT_W'(CREDITS);

  localparam logic [1:0] TypeBody     = 2'b00;
  localparam logic [1:0] TypeHead     = 2'b01;
  localparam logic [1:0] TypeTail     = 2'b10;
  localparam logic [1:0] TypeHeadTail = 2'b11;

  typedef enum logic [1:0] {StIdle, StHead, StBody} state_e;

  state_e             state;
  logic [DEST_W-1:0]  dest;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   rem_cnt;

  logic               has_credit;
  logic               send_head;
  logic               send_body;
  logic               send;
  logic [DATA_W-1:0]  head_payload;

  always_comb begin
    has_credit   = (credit_cnt != '0);
    msg_ready    = (state == StIdle);
    pld_ready    = (state == StBody) && has_credit;
    send_head    = (state == StHead) && has_credit;
    send_body    = pld_valid && pld_ready;
    send         = send_head || send_body;
    busy         = (state != StIdle);
    // Length sits directly above the destination id, upper bits zero.
    head_payload = DATA_W'({len, dest});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      dest       <= '0;
      len        <= '0;
      rem_cnt    <= '0;
      flit_valid <= 1'b0;
      flit_data  <= '0;
      credit_cnt <= CreditsMax;
      credit_err <= 1'b0;
    end else begin
      flit_valid <= 1'b0;

      unique case (state)
        StIdle: begin
          if (msg_valid) begin
            dest    <= msg_dest;
            len     <= msg_len;
            rem_cnt <= msg_len;
            state   <= StHead;
          end
        end
        StHead: begin
          if (send_head) begin
            flit_valid <= 1'b1;
            if (len == '0) begin
              flit_data <= {TypeHeadTail, head_payload};
              state     <= StIdle;
            end else begin
              flit_data <= {TypeHead, head_payload};
              state     <= StBody;
            end
          end
        end
        StBody: begin
          if (send_body) begin
            flit_valid <= 1'b1;
            rem_cnt    <= rem_cnt - LEN_W'(1);
            if (rem_cnt == LEN_W'(1)) begin
              flit_data <= {TypeTail, pld_data};
              state     <= StIdle;
            end else begin
              flit_data <= {TypeBody, pld_data};
            end
          end
        end
        default: state <= StIdle;
      endcase

      // A send and a returned credit in the same cycle cancel out.
      if (credit_in && !send) begin
        if (credit_cnt == CreditsMax) begin
          credit_err <= 1'b1;
        end else begin
          credit_cnt <= credit_cnt + CNT_W'(1);
        end
      end else if (send && !credit_in) begin
        credit_cnt <= credit_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ni_packetizer.sv
// tb_ni_packetizer: self-checking bench for ni_packetizer.
// Expected flits are queued when descriptors and payload words are handed over; a negedge
// monitor pops and compares every flit the DUT pushes and records the cycle it arrived in.
module tb_ni_packetizer;

  localparam int DATA_W  = 32;
  localparam int DEST_W  = 4;
  localparam int LEN_W   = 4;
  localparam int CREDITS = 4;
  localparam int CNT_W   = $clog2(CREDITS + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              msg_valid;
  logic              msg_ready;
  logic [DEST_W-1:0] msg_dest;
  logic [LEN_W-1:0]  msg_len;
  logic              pld_valid;
  logic              pld_ready;
  logic [DATA_W-1:0] pld_data;
  logic              flit_valid;
  logic [DATA_W+1:0] flit_data;
  logic              credit_in;
  logic [CNT_W-1:0]  credit_cnt;
  logic              credit_err;
  logic              busy;

  int                n_checks = 0;
  int                n_pass   = 0;
  int                cyc      = 0;
  int                tb_rem   = 0;
  logic [DATA_W+1:0] exp_q[$];
  logic [DATA_W+1:0] mon_exp;
  int                fcyc[$];

  ni_packetizer #(
    .DATA_W (DATA_W),
    .DEST_W (DEST_W),
    .LEN_W  (LEN_W),
    .CREDITS(CREDITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_dest  (msg_dest),
    .msg_len   (msg_len),
    .pld_valid (pld_valid),
    .pld_ready (pld_ready),
    .pld_data  (pld_data),
    .flit_valid(flit_valid),
    .flit_data (flit_data),
    .credit_in (credit_in),
    .credit_cnt(credit_cnt),
    .credit_err(credit_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Flit monitor / scoreboard.
  always @(negedge clk) begin
    if (flit_valid === 1'b1) begin
      fcyc.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL flit_unexpected: got %h, required no flit", flit_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (flit_data !== mon_exp)
          $display("FAIL flit_data: got %h, required %h", flit_data, mon_exp);
        else
          n_pass++;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic put_msg(input logic [DEST_W-1:0] d, input logic [LEN_W-1:0] l);
    int n;
    msg_valid = 1'b1;
    msg_dest  = d;
    msg_len   = l;
    #1;
    n = 0;
    while (msg_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (msg_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL msg_accept_timeout: msg_ready=%b, required 1", msg_ready);
      msg_valid = 1'b0;
      return;
    end
    exp_q.push_back({(l == 0) ? 2'b11 : 2'b01, 24'b0, l, d});
    tb_rem = int'(l);
    @(negedge clk);
    msg_valid = 1'b0;
    // Descriptor fields must be ignored after accept.
    msg_dest  = 4'($urandom);
    msg_len   = 4'($urandom);
  endtask

  task automatic put_word(input logic [DATA_W-1:0] w);
    int n;
    pld_valid = 1'b1;
    pld_data  = w;
    #1;
    n = 0;
    while (pld_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (pld_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL pld_accept_timeout: pld_ready=%b, required 1", pld_ready);
      pld_valid = 1'b0;
      return;
    end
    exp_q.push_back({(tb_rem == 1) ? 2'b10 : 2'b00, w});
    tb_rem--;
    @(negedge clk);
    pld_valid = 1'b0;
    pld_data  = $urandom;
  endtask

  task automatic pulse_credit();
    credit_in = 1'b1;
    @(negedge clk);
    credit_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      msg_valid = 1'($urandom);
      pld_valid = 1'($urandom);
      credit_in = 1'($urandom);
      msg_dest  = 4'($urandom);
      msg_len   = 4'($urandom);
      pld_data  = $urandom;
      #1;
      n_checks++;
      if ({flit_valid, credit_cnt, msg_ready, pld_ready, busy, credit_err} !==
          {1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0})
        $display("FAIL reset_outputs: fv,cnt,mr,pr,busy,err=%b,%0d,%b,%b,%b,%b required 0,4,1,0,0,0",
                 flit_valid, credit_cnt, msg_ready, pld_ready, busy, credit_err);
      else
        n_pass++;
    end
    n_checks++;
    if (flit_data !== '0) $display("FAIL reset_flit_data: got %h, required 0", flit_data);
    else n_pass++;
    @(negedge clk);
    msg_valid = 1'b0;
    pld_valid = 1'b0;
    credit_in = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream();
    fcyc.delete();
    put_msg(4'd5, 4'd3);
    put_word(32'hAAAA_0001);
    put_word(32'hBBBB_0002);
    put_word(32'hCCCC_0003);
    #1;
    n_checks++;
    if (!(fcyc.size() == 4 && fcyc[3] - fcyc[0] == 3))
      $display("FAIL stream_timing: got %0d flits, required 4 on consecutive cycles", fcyc.size());
    else n_pass++;
    n_checks++;
    if (credit_cnt !== 3'd0) $display("FAIL stream_credits: got %0d, required 0", credit_cnt);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL stream_idle: busy=%b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_stall();
    fcyc.delete();
    put_msg(4'd9, 4'd1);
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (fcyc.size() != 0 || busy !== 1'b1)
      $display("FAIL stall_no_head: flits=%0d busy=%b, required 0 flits busy=1", fcyc.size(), busy);
    else n_pass++;
    pulse_credit();
    @(negedge clk);
    #1;
    n_checks++;
    if (fcyc.size() != 1) $display("FAIL stall_one_head: got %0d flits, required 1", fcyc.size());
    else n_pass++;
    n_checks++;
    if (credit_cnt !== 3'd0) $display("FAIL stall_credits: got %0d, required 0", credit_cnt);
    else n_pass++;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (fcyc.size() != 1 || pld_ready !== 1'b0)
      $display("FAIL stall_body: flits=%0d pld_ready=%b, required 1 flit ready=0",
               fcyc.size(), pld_ready);
    else n_pass++;
    pulse_credit();
    put_word(32'hDDDD_0004);
    #1;
    n_checks++;
    if (fcyc.size() != 2 || busy !== 1'b0 || credit_cnt !== 3'd0)
      $display("FAIL stall_tail: flits=%0d busy=%b cnt=%0d, required 2,0,0",
               fcyc.size(), busy, credit_cnt);
    else n_pass++;
    repeat (4) pulse_credit();
    #1;
    n_checks++;
    if (credit_cnt !== 3'd4 || credit_err !== 1'b0)
      $display("FAIL stall_refill: cnt=%0d err=%b, required 4,0", credit_cnt, credit_err);
    else n_pass++;
  endtask

  task automatic test_credit_loop();
    fcyc.delete();
    put_msg(4'd3, 4'd6);
    credit_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      put_word(32'h1000_0000 + 32'(i));
      #1;
      n_checks++;
      if (credit_cnt !== 3'd4) $display("FAIL loop_credits_%0d: got %0d, required 4", i, credit_cnt);
      else n_pass++;
    end
    credit_in = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (!(fcyc.size() == 7 && fcyc[6] - fcyc[0] == 6) || credit_err !== 1'b0)
      $display("FAIL loop_no_stall: flits=%0d err=%b, required 7 consecutive, err=0",
               fcyc.size(), credit_err);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    logic ready_seen;
    fcyc.delete();
    put_msg(4'd2, 4'd0);
    ready_seen = 1'b0;
    pld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      ready_seen = ready_seen | pld_ready;
      @(negedge clk);
    end
    pld_valid = 1'b0;
    #1;
    n_checks++;
    if (ready_seen !== 1'b0) $display("FAIL zero_pld_ready: got %b, required 0", ready_seen);
    else n_pass++;
    n_checks++;
    if (fcyc.size() != 1 || busy !== 1'b0 || credit_cnt !== 3'd3)
      $display("FAIL zero_single_flit: flits=%0d busy=%b cnt=%0d, required 1,0,3",
               fcyc.size(), busy, credit_cnt);
    else n_pass++;
    pulse_credit();
  endtask

  task automatic test_reset_mid();
    fcyc.delete();
    put_msg(4'd7, 4'd5);
    put_word(32'h5555_0000);
    put_word(32'h5555_0001);
    #1;
    rst_n  = 1'b0;
    tb_rem = 0;
    #1;
    n_checks++;
    if (flit_valid !== 1'b0 || credit_cnt !== 3'd4 || busy !== 1'b0)
      $display("FAIL midrst_state: fv=%b cnt=%0d busy=%b, required 0,4,0",
               flit_valid, credit_cnt, busy);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (fcyc.size() != 3 || exp_q.size() != 0)
      $display("FAIL midrst_no_flits: flits=%0d pending=%0d, required 3,0", fcyc.size(), exp_q.size());
    else n_pass++;
    @(negedge clk);
    put_msg(4'd1, 4'd2);
    put_word(32'h6666_0000);
    put_word(32'h6666_0001);
    #1;
    n_checks++;
    if (fcyc.size() != 6 || credit_cnt !== 3'd1)
      $display("FAIL midrst_resume: flits=%0d cnt=%0d, required 6,1", fcyc.size(), credit_cnt);
    else n_pass++;
    repeat (3) pulse_credit();
  endtask

  task automatic test_credit_err();
    #1;
    n_checks++;
    if (credit_cnt !== 3'd4 || credit_err !== 1'b0)
      $display("FAIL err_pre: cnt=%0d err=%b, required 4,0", credit_cnt, credit_err);
    else n_pass++;
    @(negedge clk);
    pulse_credit();
    #1;
    n_checks++;
    if (credit_cnt !== 3'd4 || credit_err !== 1'b1)
      $display("FAIL err_set: cnt=%0d err=%b, required 4,1", credit_cnt, credit_err);
    else n_pass++;
    @(negedge clk);
    put_msg(4'd4, 4'd0);
    repeat (3) @(negedge clk);
    pulse_credit();
    #1;
    n_checks++;
    if (credit_err !== 1'b1 || credit_cnt !== 3'd4)
      $display("FAIL err_sticky: err=%b cnt=%0d, required 1,4", credit_err, credit_cnt);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (credit_err !== 1'b0) $display("FAIL err_clear: got %b, required 0", credit_err);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    msg_valid = 1'b0;
    msg_dest  = '0;
    msg_len   = '0;
    pld_valid = 1'b0;
    pld_data  = '0;
    credit_in = 1'b0;

    test_reset();
    test_stream();
    test_stall();
    test_credit_loop();
    test_zero_len();
    test_reset_mid();
    test_credit_err();

    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL drain: %0d flits outstanding, required 0", exp_q.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
